// File: rtl/seg_scan_rx.sv
// Scanned 6-digit segment bus receiver: settles, decodes and reassembles frames.
// Optional enable-scan stall detection is built when SEG_SCAN_RX_TIMEOUT_EN is defined.
module seg_scan_rx #(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  i_seg,
    input  logic        i_seg_dp,
    input  logic [5:0]  i_seg_enb,
    output logic [23:0] o_digits,
    output logic [5:0]  o_dp,
    output logic        o_frame_valid,
    output logic        o_err,
    output logic        o_glitch,
    output logic        o_stall
);
    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
    logic [2:0]    idx_reg, idx_next;
    logic [5:0]    mask_reg, mask_next;
    logic [23:0]   digits_reg;
    logic [5:0]    dp_reg;
    logic          valid_reg, err_reg, glitch_reg;

    logic [5:0]    enb_act, cap_bit;
    logic          seg_legal, capture, start_slot, frame_done;
    logic [2:0]    seg_idx;
    logic [3:0]    cap_code;
    logic [23:0]   shadow_digits;
    logic [5:0]    shadow_dp, slot_bad;

    function automatic logic [3:0] decode_seg(input logic [6:0] s);
        case (s)
            7'h7E:   return 4'h0;
            7'h30:   return 4'h1;
            7'h6D:   return 4'h2;
            7'h79:   return 4'h3;
            7'h33:   return 4'h4;
            7'h5B:   return 4'h5;
            7'h5F:   return 4'h6;
            7'h70:   return 4'h7;
            7'h7F:   return 4'h8;
            7'h7B:   return 4'h9;
            7'h00:   return 4'hE;
            default: return 4'hF;
        endcase
    endfunction

    // Exactly one enable low: the active-high view has a single bit set.
    always_comb begin
        enb_act   = ~i_seg_enb;
        seg_legal = (enb_act != 6'd0) && ((enb_act & (enb_act - 6'd1)) == 6'd0);
        seg_idx   = 3'd0;
        for (int k = 0; k < 6; k++) begin
            if (enb_act[k]) seg_idx = 3'(k);
        end
        cap_code = decode_seg(i_seg);
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        capture    = 1'b0;
        start_slot = 1'b0;
        cnt_inc    = cnt_reg + CW'(1);
        case (state_reg)
            IDLE: begin
                if (seg_legal) start_slot = 1'b1;
            end
            SETTLE: begin
                if (!seg_legal) begin
                    state_next = IDLE;
                end else if (seg_idx == idx_reg) begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == SETTLE_LAST) begin
                        capture    = 1'b1;
                        state_next = HOLD;
                    end
                end else begin
                    start_slot = 1'b1;
                end
            end
            HOLD: begin
                if (!seg_legal) state_next = IDLE;
                else if (seg_idx != idx_reg) start_slot = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        // A newly selected digit starts its settle count at 1 and may capture at once.
        if (start_slot) begin
            idx_next = seg_idx;
            cnt_next = CW'(1);
            if (SETTLE_CYC <= 1) begin
                capture    = 1'b1;
                state_next = HOLD;
            end else begin
                state_next = SETTLE;
            end
        end
    end

    always_comb begin
        cap_bit    = capture ? (6'd1 << seg_idx) : 6'd0;
        frame_done = (mask_reg == 6'h3F);
        // A capture on the completing edge opens the next frame.
        mask_next  = frame_done ? cap_bit : (mask_reg | cap_bit);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : gen_slot
            logic [3:0] code_reg;
            logic       slot_dp_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    code_reg    <= 4'h0;
                    slot_dp_reg <= 1'b0;
                end else if (capture && (seg_idx == 3'(gi))) begin
                    code_reg    <= cap_code;
                    slot_dp_reg <= i_seg_dp;
                end
            end
            assign shadow_digits[4*gi +: 4] = code_reg;
            assign shadow_dp[gi]            = slot_dp_reg;
            assign slot_bad[gi]             = (code_reg == 4'hF);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            idx_reg    <= 3'd0;
            mask_reg   <= 6'd0;
            digits_reg <= 24'd0;
            dp_reg     <= 6'd0;
            valid_reg  <= 1'b0;
            err_reg    <= 1'b0;
            glitch_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            mask_reg   <= mask_next;
            valid_reg  <= frame_done;
            glitch_reg <= glitch_reg | ~seg_legal;
            if (frame_done) begin
                digits_reg <= shadow_digits;
                dp_reg     <= shadow_dp;
                err_reg    <= |slot_bad;
            end
        end
    end

    assign o_digits      = digits_reg;
    assign o_dp          = dp_reg;
    assign o_frame_valid = valid_reg;
    assign o_err         = err_reg;
    assign o_glitch      = glitch_reg;

`ifdef SEG_SCAN_RX_TIMEOUT_EN
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYC);
    logic [5:0]  prev_enb_reg;
    logic [15:0] idle_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_enb_reg <= 6'd0;
            idle_cnt_reg <= 16'd0;
        end else begin
            prev_enb_reg <= i_seg_enb;
            if (i_seg_enb != prev_enb_reg)
                idle_cnt_reg <= 16'd0;
            else if (idle_cnt_reg != STALL_LIMIT)
                idle_cnt_reg <= idle_cnt_reg + 16'd1;
        end
    end

    assign o_stall = (idle_cnt_reg == STALL_LIMIT);
`else
    // No stall detection in this build; constant 0 for any legal TIMEOUT_CYC.
    assign o_stall = (TIMEOUT_CYC < 1);
`endif

endmodule

// File: tb/tb_seg_scan_rx.sv
// Directed bench for seg_scan_rx: frame decode, settle filter, errors, reset and glitch.
module tb_seg_scan_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'h7E;
    logic        seg_dp = 1'b0;
    logic [5:0]  seg_enb = 6'b111110;
    logic [23:0] digits;
    logic [5:0]  dp;
    logic        frame_valid, err, glitch, stall;

    int total = 0;
    int bad = 0;
    int pulses = 0;

    seg_scan_rx #(.SETTLE_CYC(4), .TIMEOUT_CYC(20)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_seg         (seg),
        .i_seg_dp      (seg_dp),
        .i_seg_enb     (seg_enb),
        .o_digits      (digits),
        .o_dp          (dp),
        .o_frame_valid (frame_valid),
        .o_err         (err),
        .o_glitch      (glitch),
        .o_stall       (stall)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scan(input int k, input logic [6:0] s, input logic d, input int n);
        seg_enb = ~(6'd1 << k);
        seg     = s;
        seg_dp  = d;
        tick(n);
    endtask

    task automatic wait_frame(input string tag, input int budget);
        int i = 0;
        while (!frame_valid && i < budget) begin
            tick(1);
            i++;
        end
        check(tag, 32'(frame_valid), 32'd1);
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_dp", 32'(dp), 32'h0);
        check("rst_valid", 32'(frame_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_glitch", 32'(glitch), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        rst = 1'b0;

        // Full frame 9,6,5,4,3,2 with dp on digit 2
        scan(0, 7'h7B, 1'b0, 8);
        scan(1, 7'h5F, 1'b0, 8);
        scan(2, 7'h5B, 1'b1, 8);
        scan(3, 7'h33, 1'b0, 8);
        scan(4, 7'h79, 1'b0, 8);
        scan(5, 7'h6D, 1'b0, 4);
        check("f1_latency_pre", 32'(frame_valid), 32'd0);
        tick(1);
        check("f1_valid", 32'(frame_valid), 32'd1);
        check("f1_digits", 32'(digits), 32'h234569);
        check("f1_dp", 32'(dp), 32'b000100);
        check("f1_err", 32'(err), 32'd0);
        tick(1);
        check("f1_pulse_end", 32'(frame_valid), 32'd0);
        check("f1_digits_hold", 32'(digits), 32'h234569);
        tick(2);
        check("f1_pulses", 32'(pulses), 32'd1);

        // Slots shorter than the settle time never capture
        for (int k = 0; k < 6; k++) scan(k, 7'h7E, 1'b0, 3);
        check("short_pulses", 32'(pulses), 32'd1);
        check("short_glitch", 32'(glitch), 32'd0);

        // Error (0x01 -> F) and blank (0x00 -> E) codes
        scan(0, 7'h7E, 1'b0, 8);
        scan(1, 7'h00, 1'b0, 8);
        scan(2, 7'h30, 1'b0, 8);
        scan(3, 7'h01, 1'b0, 8);
        scan(4, 7'h7F, 1'b0, 8);
        scan(5, 7'h70, 1'b0, 4);
        wait_frame("f2_valid", 3);
        check("f2_digits", 32'(digits), 32'h78F1E0);
        check("f2_dp", 32'(dp), 32'h0);
        check("f2_err", 32'(err), 32'd1);
        tick(4);
        check("f2_pulses", 32'(pulses), 32'd2);

        // Reset after four captures discards them
        for (int k = 0; k < 4; k++) scan(k, 7'h7F, 1'b1, 8);
        rst = 1'b1;
        tick(1);
        check("mid_rst_digits", 32'(digits), 32'h0);
        check("mid_rst_err", 32'(err), 32'h0);
        check("mid_rst_valid", 32'(frame_valid), 32'h0);
        check("mid_rst_dp", 32'(dp), 32'h0);
        tick(1);
        rst = 1'b0;
        scan(4, 7'h5B, 1'b0, 8);
        scan(5, 7'h5F, 1'b1, 8);
        check("post_rst_no_early", 32'(pulses), 32'd2);
        check("post_rst_digits_zero", 32'(digits), 32'h0);
        scan(0, 7'h30, 1'b1, 8);
        scan(1, 7'h6D, 1'b0, 8);
        scan(2, 7'h79, 1'b0, 8);
        scan(3, 7'h33, 1'b0, 4);
        wait_frame("f3_valid", 3);
        check("f3_digits", 32'(digits), 32'h654321);
        check("f3_dp", 32'(dp), 32'b100001);
        check("f3_err", 32'(err), 32'd0);
        tick(4);
        check("f3_pulses", 32'(pulses), 32'd3);

        // Illegal enables interrupt digit 3
        scan(0, 7'h7E, 1'b0, 8);
        scan(1, 7'h30, 1'b0, 8);
        scan(2, 7'h6D, 1'b0, 8);
        scan(3, 7'h79, 1'b0, 2);
        seg_enb = 6'b111111;
        tick(2);
        check("glitch_set", 32'(glitch), 32'd1);
        seg_enb = 6'b111100;
        tick(2);
        scan(4, 7'h33, 1'b0, 8);
        scan(5, 7'h5B, 1'b0, 8);
        check("glitch_no_frame", 32'(pulses), 32'd3);
        check("glitch_sticky", 32'(glitch), 32'd1);
        scan(3, 7'h79, 1'b0, 4);
        wait_frame("f4_valid", 3);
        check("f4_digits", 32'(digits), 32'h543210);
        check("f4_err", 32'(err), 32'd0);
        tick(4);
        check("f4_pulses", 32'(pulses), 32'd4);
        check("f4_glitch", 32'(glitch), 32'd1);

        // Frozen enable
        scan(0, 7'h7E, 1'b0, 25);
`ifdef SEG_SCAN_RX_TIMEOUT_EN
        check("stall_set", 32'(stall), 32'd1);
        scan(1, 7'h30, 1'b0, 1);
        check("stall_drop", 32'(stall), 32'd0);
`else
        check("stall_off", 32'(stall), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_scan_rx.md
Name: seg_scan_rx

Overview:
Receive-side counterpart of the scanned 6-digit LED display path. Samples the time-multiplexed segment bus (segments + dp + digit enables), waits for each digit slot to settle, and decodes each 7-seg pattern back to a 4-bit code. Reassembles a full 6-digit frame. Used as an on-chip loopback checker and bench monitor behind the display driver.

Parameters:
SETTLE_CYC, 4, consecutive cycles the digit enable must be stable before its segments are sampled (min 1).
TIMEOUT_CYC, 65535, cycles without an enable change before stall is flagged (optional feature only).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_seg  in  7  segment bus {a,b,c,d,e,f,g}, bit6=a; 1 = lit
i_seg_dp  in  1  decimal point for the selected digit; 1 = lit
i_seg_enb  in  6  digit enables, active-low one-hot; bit k=0 selects digit k (digit 5 = leftmost)
o_digits  out  24  frame codes, digit k at [4k+3:4k]
o_dp  out  6  frame dp bits, digit k at bit k
o_frame_valid  out  1  one-cycle pulse: o_digits/o_dp hold a newly completed frame
o_err  out  1  high for the frame just pulsed if any digit decoded to 4'hF
o_glitch  out  1  sticky: a non-one-hot enable was seen; cleared by rst only
o_stall  out  1  enable scan stopped (optional feature; else tied 0)

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, capture mask 0, settle counter 0, FSM to IDLE. Reset mid-frame discards partial captures.
- Legal enable: exactly one bit of i_seg_enb is 0. Anything else is illegal.
- FSM:
  - IDLE: on legal enable, latch its index, load settle count 1 -> SETTLE.
  - SETTLE: same enable as previous cycle -> count+1. When count reaches SETTLE_CYC, capture -> HOLD. Enable changed to another legal value -> relatch, count 1, stay. Illegal -> IDLE.
  - HOLD: stay while enable unchanged; no recapture. On a different legal enable -> SETTLE, count 1. Illegal -> IDLE.
- Any illegal enable sets o_glitch. No capture for that slot.
- Capture writes the decoded code and i_seg_dp into the digit's shadow slot, and sets mask bit k. SETTLE_CYC=1 captures on the first cycle the enable is seen.
- Decode (i_seg hex -> code):
  - digits: 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9
  - 00->E (blank)
  - any other pattern -> F (error)
- Re-capture of the same digit before the frame completes overwrites its slot; the mask is unchanged.
- Frame completion: when the capture makes mask 6'b111111, then on the next edge:
  - o_digits/o_dp load from the shadow slots
  - o_err = any slot is F
  - o_frame_valid pulses for 1 cycle
  - the mask clears to 0
- Latency: last digit sampled at edge N -> o_frame_valid high in cycle N+1.
- A capture coinciding with completion belongs to the next frame; the mask becomes that single bit.
- o_digits/o_dp/o_err hold between pulses. Scan order is irrelevant; only coverage of all six digits matters.

Optional Feature:
Macro SEG_SCAN_RX_TIMEOUT_EN.
- Defined: a 16-bit idle counter increments each cycle i_seg_enb equals its previous-cycle value, saturating at TIMEOUT_CYC; any change clears it.
  - o_stall = (counter == TIMEOUT_CYC), dropping the cycle after any enable change.
  - Frames still complete normally.
- Undefined: counter absent, o_stall constant 0.

Test Plan:
- SETTLE_CYC=4; scan digits 0..5 with patterns 7B,5F,5B,33,79,6D, 8 cycles per slot, dp only on digit 2 -> one o_frame_valid pulse 1 cycle after digit-5 capture; o_digits=24'h234569, o_dp=6'b000100, o_err=0.
- Hold each slot only 3 cycles with SETTLE_CYC=4 -> no capture, o_frame_valid never asserts, o_glitch stays 0.
- Insert i_seg_enb=6'b111111 and then 6'b111100 between slots -> o_glitch=1 and stays 1; the interrupted slot is not captured; the frame completes only after that digit is rescanned legally.
- Digit 3 pattern 0x01 and digit 1 pattern 0x00, others valid -> digit 3 code F, digit 1 code E, o_err=1 with the pulse.
- Assert rst after 4 digits captured, then scan all 6 -> exactly one frame pulse, containing only post-reset data; all outputs 0 during and after reset.
- SEG_SCAN_RX_TIMEOUT_EN defined, TIMEOUT_CYC=20, freeze enable on digit 0 -> o_stall=1 after 20 stable cycles; drops 1 cycle after the enable changes; undefined build -> o_stall=0 throughout.
